// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory arbiter slice.
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int BYTE_EN_W  = MEM_DATA_W / 8;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP
    } arb_state_t;

    // Command captured at accept time and replayed to the memory in CMD.
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [BYTE_EN_W-1:0]  byte_en;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // True when the low address bits do not name a word boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-way round-robin pick. A sole requester always wins; on a tie the
// port that did not win last time is chosen.
module mips_rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic grant
);

    logic last_grant;

    // Winner selection: sole requester first, otherwise alternate.
    always_comb begin
        grant = ~last_grant;
        if (req0 && !req1) begin
            grant = 1'b0;
        end else if (req1 && !req0) begin
            grant = 1'b1;
        end
    end

    // Remember the last accepted port; starting at 1 hands port 0 the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant_en && (req0 || req1)) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the single-port MIPS memory between instruction fetch (port 0) and
// the load/store unit (port 1). Each access runs IDLE -> CMD -> RESP, so the
// peak rate is one transaction every three cycles.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W/8-1:0]   p0_byte_en,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_done,
    output logic                  p0_err,
    output logic [DATA_W-1:0]     p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W/8-1:0]   p1_byte_en,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_done,
    output logic                  p1_err,
    output logic [DATA_W-1:0]     p1_rdata,

    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_wr_en,
    output logic                  mem_read_en,
    output logic [DATA_W/8-1:0]   mem_byte_en,
    output logic [DATA_W-1:0]     mem_data_in,
    input  logic [DATA_W-1:0]     mem_data_out,

    output logic                  busy
);

    arb_state_t state, state_d;
    mem_req_t   req_q, req_d;
    logic       winner_q, winner_d;
    logic       err_q, err_d;

    logic       grant;
    logic       grant_en;

    logic                ack0_d, ack1_d;
    logic                done0_d, done1_d;
    logic                err0_d, err1_d;
    logic                rd_sel0_d, rd_sel1_d;
    logic                rd_sel0_q, rd_sel1_q;
    logic [ADDR_W-1:0]   mem_address_d;
    logic                mem_wr_en_d, mem_read_en_d;
    logic [DATA_W/8-1:0] mem_byte_en_d;
    logic [DATA_W-1:0]   mem_data_in_d;

    mips_rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (p0_req),
        .req1     (p1_req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // Next state plus the value every registered output takes in the next cycle.
    always_comb begin
        state_d       = state;
        req_d         = req_q;
        winner_d      = winner_q;
        err_d         = err_q;
        grant_en      = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rd_sel0_d     = 1'b0;
        rd_sel1_d     = 1'b0;
        mem_address_d = '0;
        mem_wr_en_d   = 1'b0;
        mem_read_en_d = 1'b0;
        mem_byte_en_d = '0;
        mem_data_in_d = '0;

        case (state)
            IDLE: begin
                grant_en = 1'b1;
                if (p0_req || p1_req) begin
                    winner_d = grant;
                    if (grant) begin
                        req_d.we      = p1_we;
                        req_d.addr    = p1_addr;
                        req_d.byte_en = p1_byte_en;
                        req_d.wdata   = p1_wdata;
                    end else begin
                        req_d.we      = p0_we;
                        req_d.addr    = p0_addr;
                        req_d.byte_en = p0_byte_en;
                        req_d.wdata   = p0_wdata;
                    end
                    err_d         = ALIGN_CHECK && is_misaligned(req_d.addr[1:0]);
                    state_d       = CMD;
                    ack0_d        = !grant;
                    ack1_d        = grant;
                    mem_address_d = req_d.addr;
                    mem_byte_en_d = req_d.byte_en;
                    mem_data_in_d = req_d.wdata;
                    mem_wr_en_d   = req_d.we && !err_d;
                    mem_read_en_d = !req_d.we && !err_d;
                end
            end
            CMD: begin
                state_d   = RESP;
                done0_d   = !winner_q;
                done1_d   = winner_q;
                err0_d    = !winner_q && err_q;
                err1_d    = winner_q && err_q;
                rd_sel0_d = !winner_q && !req_q.we && !err_q;
                rd_sel1_d = winner_q && !req_q.we && !err_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched command and all port/memory outputs; reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_q       <= '0;
            winner_q    <= 1'b0;
            err_q       <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_err      <= 1'b0;
            p1_err      <= 1'b0;
            rd_sel0_q   <= 1'b0;
            rd_sel1_q   <= 1'b0;
            mem_address <= '0;
            mem_wr_en   <= 1'b0;
            mem_read_en <= 1'b0;
            mem_byte_en <= '0;
            mem_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            winner_q    <= winner_d;
            err_q       <= err_d;
            p0_ack      <= ack0_d;
            p1_ack      <= ack1_d;
            p0_done     <= done0_d;
            p1_done     <= done1_d;
            p0_err      <= err0_d;
            p1_err      <= err1_d;
            rd_sel0_q   <= rd_sel0_d;
            rd_sel1_q   <= rd_sel1_d;
            mem_address <= mem_address_d;
            mem_wr_en   <= mem_wr_en_d;
            mem_read_en <= mem_read_en_d;
            mem_byte_en <= mem_byte_en_d;
            mem_data_in <= mem_data_in_d;
            busy        <= (state_d != IDLE);
        end
    end

    // Memory read data only arrives in the RESP cycle, so it is steered to the
    // winning port by a registered select rather than re-registered.
    assign p0_rdata = rd_sel0_q ? mem_data_out : '0;
    assign p1_rdata = rd_sel1_q ? mem_data_out : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter. A second instance with
// the alignment check disabled shares the same requester inputs.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_byte_en, p1_byte_en;

    logic        p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_wr_en, mem_read_en, busy;
    logic [3:0]  mem_byte_en;

    logic        na_p0_ack, na_p0_done, na_p0_err, na_p1_ack, na_p1_done, na_p1_err;
    logic [31:0] na_p0_rdata, na_p1_rdata;
    logic [31:0] na_mem_address, na_mem_data_in, na_mem_data_out;
    logic        na_mem_wr_en, na_mem_read_en, na_busy;
    logic [3:0]  na_mem_byte_en;

    logic [31:0] mem_rd_value;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int done_count  = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_byte_en(p0_byte_en),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_done(p0_done), .p0_err(p0_err),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_byte_en(p1_byte_en),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_done(p1_done), .p1_err(p1_err),
        .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
        .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ALIGN_CHECK(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_byte_en(p0_byte_en),
        .p0_wdata(p0_wdata), .p0_ack(na_p0_ack), .p0_done(na_p0_done), .p0_err(na_p0_err),
        .p0_rdata(na_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_byte_en(p1_byte_en),
        .p1_wdata(p1_wdata), .p1_ack(na_p1_ack), .p1_done(na_p1_done), .p1_err(na_p1_err),
        .p1_rdata(na_p1_rdata),
        .mem_address(na_mem_address), .mem_wr_en(na_mem_wr_en), .mem_read_en(na_mem_read_en),
        .mem_byte_en(na_mem_byte_en), .mem_data_in(na_mem_data_in),
        .mem_data_out(na_mem_data_out), .busy(na_busy)
    );

    // Memory stand-ins: registered read data, zero whenever no read was issued.
    always @(posedge clk) begin
        mem_data_out    <= mem_read_en ? mem_rd_value : 32'h0;
        na_mem_data_out <= na_mem_read_en ? mem_rd_value : 32'h0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_byte_en = be; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_byte_en = be; p0_wdata = wdata;
        end
    endtask

    // Advance to the sampling point (falling edge) of the next cycle.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rd_value = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Reset state
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_en", {30'd0, mem_wr_en, mem_read_en}, 32'd0);
        checkOutput("rst_acks", {28'd0, p0_ack, p0_done, p1_ack, p1_done}, 32'd0);
        rst_n = 1'b1;

        // Test 1: lone p0 read of 0x100
        $display("[TB] p0 single read");
        mem_rd_value = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        checkOutput("t1_idle_ack", {31'd0, p0_ack}, 32'd0);
        cyc();
        checkOutput("t1_p0_ack", {31'd0, p0_ack}, 32'd1);
        checkOutput("t1_rd_en", {31'd0, mem_read_en}, 32'd1);
        checkOutput("t1_wr_en", {31'd0, mem_wr_en}, 32'd0);
        checkOutput("t1_addr", mem_address, 32'h100);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        checkOutput("t1_p1_cmd", {30'd0, p1_ack, p1_done}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t1_p0_done", {31'd0, p0_done}, 32'd1);
        checkOutput("t1_p0_err", {31'd0, p0_err}, 32'd0);
        checkOutput("t1_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("t1_ack_gone", {31'd0, p0_ack}, 32'd0);
        checkOutput("t1_resp_rd_en", {31'd0, mem_read_en}, 32'd0);
        checkOutput("t1_p1_resp", {30'd0, p1_ack, p1_done}, 32'd0);
        checkOutput("t1_p1_rdata", p1_rdata, 32'h0);
        cyc();
        checkOutput("t1_done_once", {31'd0, p0_done}, 32'd0);
        checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("t1_idle_rdata", p0_rdata, 32'h0);

        // Test 2: tie after reset, p0 read then p1 write
        $display("[TB] simultaneous p0 read / p1 write");
        applyReset();
        mem_rd_value = 32'hCAFEF00D;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 4'hF, 32'h11223344);
        cyc();
        checkOutput("t2_p0_first", {30'd0, p0_ack, p1_ack}, 32'b10);
        checkOutput("t2_rd_addr", mem_address, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t2_p0_done", {30'd0, p0_done, p1_done}, 32'b10);
        checkOutput("t2_p0_rdata", p0_rdata, 32'hCAFEF00D);
        cyc();
        checkOutput("t2_gap", {30'd0, p1_ack, busy}, 32'd0);
        cyc();
        checkOutput("t2_p1_ack", {30'd0, p0_ack, p1_ack}, 32'b01);
        checkOutput("t2_wr_en", {30'd0, mem_wr_en, mem_read_en}, 32'b10);
        checkOutput("t2_wr_addr", mem_address, 32'h200);
        checkOutput("t2_wdata", mem_data_in, 32'h11223344);
        checkOutput("t2_be", {28'd0, mem_byte_en}, 32'hF);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t2_p1_done", {31'd0, p1_done}, 32'd1);
        checkOutput("t2_p1_err", {31'd0, p1_err}, 32'd0);
        checkOutput("t2_p1_rdata", p1_rdata, 32'h0);
        cyc();

        // Test 3: both ports hold req for six transactions
        $display("[TB] continuous contention");
        mem_rd_value = 32'h5A5A0F0F;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        done_count = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            checkOutput($sformatf("t3_ack_%0d", k), {30'd0, p0_ack, p1_ack},
                        (k % 2 == 0) ? 32'b10 : 32'b01);
            checkOutput($sformatf("t3_addr_%0d", k), mem_address,
                        (k % 2 == 0) ? 32'h10 : 32'h20);
            done_count += int'(p0_done) + int'(p1_done);
            cyc();
            checkOutput($sformatf("t3_done_%0d", k), {30'd0, p0_done, p1_done},
                        (k % 2 == 0) ? 32'b10 : 32'b01);
            done_count += int'(p0_done) + int'(p1_done);
            cyc();
            checkOutput($sformatf("t3_idle_%0d", k), {28'd0, p0_ack, p1_ack, p0_done, p1_done}, 32'd0);
            done_count += int'(p0_done) + int'(p1_done);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("t3_done_total", done_count, 32'd6);

        // Test 4: misaligned p1 read, with and without the alignment check
        $display("[TB] misaligned p1 read");
        mem_rd_value = 32'h01020304;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h203, 4'hF, 32'h0);
        cyc();
        checkOutput("t4_ack", {31'd0, p1_ack}, 32'd1);
        checkOutput("t4_no_access", {30'd0, mem_wr_en, mem_read_en}, 32'd0);
        checkOutput("t4_na_rd_en", {30'd0, na_mem_wr_en, na_mem_read_en}, 32'b01);
        checkOutput("t4_na_addr", na_mem_address, 32'h203);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t4_done_err", {30'd0, p1_done, p1_err}, 32'b11);
        checkOutput("t4_err_rdata", p1_rdata, 32'h0);
        checkOutput("t4_na_done_err", {30'd0, na_p1_done, na_p1_err}, 32'b10);
        checkOutput("t4_na_rdata", na_p1_rdata, 32'h01020304);
        cyc();
        checkOutput("t4_err_clear", {31'd0, p1_err}, 32'd0);

        // Test 5: partial byte-lane write
        $display("[TB] partial byte write");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h204, 4'b0010, 32'hAABBCCDD);
        cyc();
        checkOutput("t5_be", {28'd0, mem_byte_en}, 32'b0010);
        checkOutput("t5_wr_en", {31'd0, mem_wr_en}, 32'd1);
        checkOutput("t5_wdata", mem_data_in, 32'hAABBCCDD);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t5_done", {31'd0, p1_done}, 32'd1);
        cyc();

        // Test 6: asynchronous reset in the middle of a write command
        $display("[TB] async reset during CMD");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 4'hF, 32'h77777777);
        cyc();
        checkOutput("t6_cmd_wr", {31'd0, mem_wr_en}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_wr", {31'd0, mem_wr_en}, 32'd0);
        checkOutput("t6_async_na_wr", {31'd0, na_mem_wr_en}, 32'd0);
        checkOutput("t6_async_busy", {30'd0, busy, p1_ack}, 32'd0);
        @(negedge clk);
        checkOutput("t6_no_done_a", {31'd0, p1_done}, 32'd0);
        @(negedge clk);
        checkOutput("t6_no_done_b", {30'd0, p1_done, mem_wr_en}, 32'd0);
        rst_n = 1'b1;
        cyc();
        checkOutput("t6_post_idle", {30'd0, busy, p1_done}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        cyc();
        checkOutput("t6_tie_p0", {30'd0, p0_ack, p1_ack}, 32'b10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        checkOutput("t6_p0_done", {30'd0, p0_done, p1_done}, 32'b10);
        cyc();
        cyc();
        checkOutput("t6_then_p1", {30'd0, p0_ack, p1_ack}, 32'b01);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port byte-addressed MIPS memory between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Arbitrates round-robin and sequences each access through the memory's one-cycle registered command/read timing.
- Returns read data and a completion pulse to the winning port.
- Sits between the CPU core and mips_memory.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- ALIGN_CHECK, 1, when 1, reject requests whose addr[1:0] != 0 with an error completion and no memory access.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pN_req  in  1  port N (N=0,1) request; held with fields stable until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  ADDR_W  byte address.
- pN_byte_en  in  DATA_W/8  byte lanes for writes.
- pN_wdata  in  DATA_W  write data.
- pN_ack  out  1  one-cycle pulse: request latched.
- pN_done  out  1  one-cycle pulse: transaction complete.
- pN_err  out  1  qualifies pN_done: misaligned, no access made.
- pN_rdata  out  DATA_W  read data, valid when pN_done=1 and read.
- mem_address  out  ADDR_W  to memory.
- mem_wr_en  out  1  to memory.
- mem_read_en  out  1  to memory.
- mem_byte_en  out  DATA_W/8  to memory.
- mem_data_in  out  DATA_W  to memory.
- mem_data_out  in  DATA_W  from memory; valid the cycle after the read command edge.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1. All outputs, all mem_* outputs and busy are 0 immediately. An in-flight transaction is abandoned with no done pulse. Memory commands must never be asserted during reset.
- FSM states IDLE, CMD, RESP. All outputs are registered.
- IDLE, at posedge with no req: stay in IDLE.
- IDLE, at posedge with any req: pick winner, latch its we/addr/byte_en/wdata, go to CMD.
- IDLE, misaligned request (ALIGN_CHECK=1): accept it and go to CMD, with that transaction flagged err.
- Arbitration: a sole requester wins. On a tie, the port != last_grant wins. last_grant updates on every accept, so port 0 wins the first tie after reset.
- CMD, one cycle:
  - winner's pN_ack=1.
  - mem_address/mem_byte_en/mem_data_in drive the latched values.
  - Without err: mem_wr_en=we, mem_read_en=!we.
  - With err: both enables 0.
  - Next posedge: go to RESP.
- RESP, one cycle:
  - winner's pN_done=1 and pN_err=err.
  - Read: pN_rdata=mem_data_out, passed unchanged with no byte swapping.
  - Write or err: pN_rdata=0.
  - mem_* enables 0.
  - Next posedge: go to IDLE.
- Non-winner outputs stay 0 throughout. Only one done pulse per accept.
- Latency: accept edge E, ack in cycle E+1, memory access at edge E+1, done in cycle E+2. Earliest next accept is edge E+3. Peak throughput is one transaction per 3 cycles.
- The requester must drop or change req after seeing ack. The arbiter samples req only in IDLE, so a held req after done is a new request.
- A req deasserted before ack is legal and dropped. A req changed while the arbiter is not in IDLE has no effect.
- Address wrap: addresses are passed unmodified; this block does no +1..+3 arithmetic.

Decomposition:
- Package mips_mem_pkg:
  - typedef arb_state_t {IDLE, CMD, RESP}.
  - constants BYTE_EN_W = DATA_W/8 and WORD_ALIGN_MASK = 2'b11.
  - struct mem_req_t {we, addr, byte_en, wdata}, used for the latched command.
- One natural sub-module: mips_rr_arbiter2, the two-way round-robin pick with last_grant state and a grant-enable input.

Test Plan:
- Reset then p0 read only: p0 addr=0x100, mem_data_out returns 0xDEADBEEF. Required: p0_ack in cycle 1, mem_read_en=1 with mem_address=0x100 in cycle 1, p0_done=1 and p0_rdata=0xDEADBEEF in cycle 2, p1 outputs 0 throughout.
- Simultaneous p0 read 0x0 and p1 write 0x200, wdata=0x11223344, byte_en=4'b1111, both held. Required: p0 granted first; p1 acked 3 cycles later with mem_wr_en=1; p1_done with p1_rdata=0.
- Both ports hold req continuously for 6 transactions. Required: grants alternate 0,1,0,1,0,1; exactly 6 done pulses spaced 3 cycles apart.
- p1 read of addr=0x203, ALIGN_CHECK=1. Required: p1_ack, mem_read_en and mem_wr_en stay 0, p1_done=1 with p1_err=1. Repeat with ALIGN_CHECK=0: a normal access to 0x203, err=0.
- p1 write with byte_en=4'b0010. Required: mem_byte_en=4'b0010 in the CMD cycle.
- Assert rst_n=0 asynchronously during CMD of a write. Required: mem_wr_en falls without waiting for a clock edge; no done pulse; after release, state=IDLE and the first tie goes to p0.
